// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8N1 UART receiver with a small memory-mapped register block.
// Registers: 0x0 RXDATA (RO), 0x4 STATUS, 0x8 CTRL (baud divider), 0xC reserved.
module uart_rx_ctrl #(
    parameter int unsigned BAUD_DIV_DEFAULT = 868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        irq_rx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    localparam logic [15:0] DIV_RESET = 16'(BAUD_DIV_DEFAULT);

    // Receiver state
    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_div_lat;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;

    // Line synchronizer and edge detector
    logic        r_rx_meta;
    logic        r_rx_s;
    logic        r_rx_prev;
    logic [1:0]  r_sync_fill;

    // Architectural registers
    logic [7:0]  r_rxdata;
    logic        r_rx_valid;
    logic        r_overrun;
    logic        r_frame_err;
    logic [15:0] r_baud_div;

    // FSM control strobes
    logic        w_load_half;
    logic        w_load_full;
    logic        w_clr_idx;
    logic        w_data_smp;
    logic        w_complete;

    logic        w_fall;
    logic        w_cnt_zero;
    logic        w_rx_busy;
    logic [15:0] w_div_eff;
    logic [15:0] w_half;
    logic        w_rd_rxdata;
    logic        w_wr_status;
    logic        w_wr_ctrl;

    // Bits of the bus that carry no meaning for this block.
    logic        w_unused_bits;
    assign w_unused_bits = ^{req_addr[31:4], req_wdata[31:16], req_wstrb};

    assign w_rd_rxdata = req_valid && !req_write && (req_addr[3:0] == 4'h0);
    assign w_wr_status = req_valid &&  req_write && (req_addr[3:0] == 4'h4);
    assign w_wr_ctrl   = req_valid &&  req_write && (req_addr[3:0] == 4'h8);

    // Dividers below 2 would leave no room for a half-bit wait.
    assign w_div_eff  = (r_baud_div < 16'd2) ? 16'd2 : r_baud_div;
    assign w_half     = w_div_eff >> 1;
    assign w_cnt_zero = (r_cnt == 16'd0);
    assign w_rx_busy  = (r_state != S_IDLE);

    // r_rx_prev only holds a real line sample once the synchronizer has
    // filled after reset, so a line held low at release never looks like a start.
    assign w_fall = r_rx_prev && !r_rx_s;

    // Synchronize the asynchronous serial line and track its previous value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_rx_prev   <= 1'b0;
            r_sync_fill <= 2'b00;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge values regardless of statement order.
            r_rx_meta   <= uart_rx;
            r_rx_s      <= r_rx_meta;
            r_rx_prev   <= r_sync_fill[1] ? r_rx_s : 1'b0;
            r_sync_fill <= {r_sync_fill[0], 1'b1};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and datapath control strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        w_state_nxt = r_state;
        w_load_half = 1'b0;
        w_load_full = 1'b0;
        w_clr_idx   = 1'b0;
        w_data_smp  = 1'b0;
        w_complete  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_load_half = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_cnt_zero) begin
                    if (r_rx_s) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_load_full = 1'b1;
                        w_clr_idx   = 1'b1;
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_cnt_zero) begin
                    w_data_smp  = 1'b1;
                    w_load_full = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_cnt_zero) begin
                    w_complete  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bit-timing counter, latched divider, bit index and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_lat <= 16'd0;
            r_cnt     <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            if (w_load_half) begin
                r_div_lat <= w_div_eff;
                r_cnt     <= w_half - 16'd1;
            end else if (w_load_full) begin
                r_cnt     <= r_div_lat - 16'd1;
            end else if (!w_cnt_zero) begin
                r_cnt     <= r_cnt - 16'd1;
            end

            if (w_clr_idx) begin
                r_bit_idx <= 3'd0;
            end else if (w_data_smp) begin
                r_shift[r_bit_idx] <= r_rx_s;
                r_bit_idx          <= r_bit_idx + 3'd1;
            end
        end
    end

    // Byte delivery, rx_valid handshake and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxdata    <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            // A read in the completion cycle frees the holding register for the new byte.
            if (w_complete) begin
                if (!r_rx_valid || w_rd_rxdata) begin
                    r_rxdata   <= r_shift;
                    r_rx_valid <= 1'b1;
                end
            end else if (w_rd_rxdata) begin
                r_rx_valid <= 1'b0;
            end

            // Error sets take priority over a simultaneous W1C clear.
            if (w_complete && r_rx_valid && !w_rd_rxdata) begin
                r_overrun <= 1'b1;
            end else if (w_wr_status && req_wdata[1]) begin
                r_overrun <= 1'b0;
            end

            if (w_complete && !r_rx_s) begin
                r_frame_err <= 1'b1;
            end else if (w_wr_status && req_wdata[2]) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    // CTRL register: the divider is only picked up at the next start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_div <= DIV_RESET;
        end else if (w_wr_ctrl) begin
            r_baud_div <= req_wdata[15:0];
        end
    end

    // Combinational read mux on the decoded offset.
    always_comb begin
        rdata = 32'h0;
        unique case (req_addr[3:0])
            4'h0:    rdata = {24'h0, r_rxdata};
            4'h4:    rdata = {28'h0, w_rx_busy, r_frame_err, r_overrun, r_rx_valid};
            4'h8:    rdata = {16'h0, r_baud_div};
            default: rdata = 32'h0;
        endcase
    end

    assign irq_rx = r_rx_valid;

endmodule
